control_sequencer: RTL and testbench

- Hardwired control unit that sits directly upstream of the CPU datapath and drives every bus-out select, register-in enable, ALU op and memory strobe in a timed fetch/decode/execute sequence.
- Consumes the IR contents and a memory ready handshake.
- Instruction fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].

---
 rtl/cpu_ctrl_pkg.sv | 68 ++++++
 rtl/instr_decode.sv | 37 +++
 rtl/control_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control sequencer: opcodes, ALU codes,
// state encoding, opcode classes and instruction field positions.
package cpu_ctrl_pkg;

  localparam int OP_W   = 5;
  localparam int N_REGS = 16;
  localparam int REG_W  = 4;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;
  localparam int C_LSB   = 0;
  localparam int C_W     = 19;

  localparam logic [OP_W-1:0] OP_LD   = 5'd0;
  localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OP_W-1:0] OP_ST   = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_AND  = 5'd5;
  localparam logic [OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd7;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd8;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd9;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd10;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd11;
  localparam logic [OP_W-1:0] OP_ANDI = 5'd12;
  localparam logic [OP_W-1:0] OP_ORI  = 5'd13;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd14;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd15;
  localparam logic [OP_W-1:0] OP_NOP  = 5'd26;
  localparam logic [OP_W-1:0] OP_HALT = 5'd27;

  // ALU operations share the opcode numbering; address arithmetic uses add.
  localparam logic [OP_W-1:0] ALU_NONE = 5'd0;
  localparam logic [OP_W-1:0] ALU_ADD  = OP_ADD;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    CLS_RTYPE   = 4'd0,
    CLS_IMM     = 4'd1,
    CLS_LDI     = 4'd2,
    CLS_LD      = 4'd3,
    CLS_ST      = 4'd4,
    CLS_MULDIV  = 4'd5,
    CLS_NOP     = 4'd6,
    CLS_HALT    = 4'd7,
    CLS_ILLEGAL = 4'd8
  } op_class_e;

  function automatic logic [N_REGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    reg_onehot = {{(N_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: opcode class plus one-hot register selects.
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0]       ir,
  output op_class_e         op_class,
  output logic [OP_W-1:0]   opcode,
  output logic [N_REGS-1:0] ra_sel,
  output logic [N_REGS-1:0] rb_sel,
  output logic [N_REGS-1:0] rc_sel
);

  // Low C bits only feed the datapath's sign extender, never the controller.
  logic unused_c_bits;
  assign unused_c_bits = ^ir[RC_LSB-1:C_LSB];

  assign opcode = ir[OPC_LSB +: OP_W];
  assign ra_sel = reg_onehot(ir[RA_LSB +: REG_W]);
  assign rb_sel = reg_onehot(ir[RB_LSB +: REG_W]);
  assign rc_sel = reg_onehot(ir[RC_LSB +: REG_W]);

  always_comb begin
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       op_class = CLS_IMM;
      OP_LDI:                         op_class = CLS_LDI;
      OP_LD:                          op_class = CLS_LD;
      OP_ST:                          op_class = CLS_ST;
      OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
      OP_NOP:                         op_class = CLS_NOP;
      OP_HALT:                        op_class = CLS_HALT;
      default:                        op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit driving the CPU datapath strobes.
// Optional ILLEGAL_TRAP_EN: undefined opcodes set a sticky flag and halt.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       ir,
  input  logic              mem_ready,
  input  logic              stop,
  output logic [N_REGS-1:0] gp_out,
  output logic [N_REGS-1:0] gp_in,
  output logic              HIout,
  output logic              LOout,
  output logic              Zhighout,
  output logic              Zlowout,
  output logic              PCout,
  output logic              MDRout,
  output logic              Cout,
  output logic              HIin,
  output logic              LOin,
  output logic              Zin,
  output logic              PCin,
  output logic              MDRin,
  output logic              MARin,
  output logic              IRin,
  output logic              Yin,
  output logic              IncPC,
  output logic              Read,
  output logic              Write,
  output logic [OP_W-1:0]   alu_op,
  output logic              running,
  output logic              illegal,
  output logic [3:0]        step
);

  state_e            state;
  state_e            state_nxt;
  state_e            end_of_instr;
  logic              stop_pend;
  op_class_e         op_class;
  logic [OP_W-1:0]   opcode;
  logic [N_REGS-1:0] ra_sel;
  logic [N_REGS-1:0] rb_sel;
  logic [N_REGS-1:0] rc_sel;

  instr_decode u_decode (
    .ir       (ir),
    .op_class (op_class),
    .opcode   (opcode),
    .ra_sel   (ra_sel),
    .rb_sel   (rb_sel),
    .rc_sel   (rc_sel)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A stop pulse seen mid-instruction is held until the next instruction boundary.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                                         stop_pend <= 1'b0;
    else if (state_nxt == ST_T0 || state_nxt == ST_HALT) stop_pend <= 1'b0;
    else if (stop)                                      stop_pend <= 1'b1;
    else                                                stop_pend <= stop_pend;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_r;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                                          illegal_r <= 1'b0;
    else if (state == ST_T3 && op_class == CLS_ILLEGAL) illegal_r <= 1'b1;
    else                                                 illegal_r <= illegal_r;
  end

  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

  assign step = state;

  always_comb begin
    end_of_instr = (stop || stop_pend) ? ST_HALT : ST_T0;
    state_nxt    = state;
    case (state)
      ST_IDLE: state_nxt = end_of_instr;
      ST_T0:   state_nxt = ST_T1;
      ST_T1:   state_nxt = mem_ready ? ST_T2 : ST_T1;
      ST_T2:   state_nxt = ST_T3;
      ST_T3: begin
        case (op_class)
          CLS_NOP:     state_nxt = end_of_instr;
          CLS_HALT:    state_nxt = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
          CLS_ILLEGAL: state_nxt = ST_HALT;
`else
          CLS_ILLEGAL: state_nxt = end_of_instr;
`endif
          default:     state_nxt = ST_T4;
        endcase
      end
      ST_T4:   state_nxt = ST_T5;
      ST_T5: begin
        case (op_class)
          CLS_LD, CLS_ST, CLS_MULDIV: state_nxt = ST_T6;
          default:                    state_nxt = end_of_instr;
        endcase
      end
      ST_T6: begin
        case (op_class)
          CLS_LD:  state_nxt = mem_ready ? ST_T7 : ST_T6;
          CLS_ST:  state_nxt = ST_T7;
          default: state_nxt = end_of_instr;
        endcase
      end
      ST_T7: begin
        if (op_class == CLS_ST && !mem_ready) state_nxt = ST_T7;
        else                                   state_nxt = end_of_instr;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore strobe decode; each state drives at most one bus-out source.
  always_comb begin
    gp_out   = '0;
    gp_in    = '0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    PCout    = 1'b0;
    MDRout   = 1'b0;
    Cout     = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    MARin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    alu_op   = ALU_NONE;
    running  = (state != ST_IDLE) && (state != ST_HALT);
    case (state)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        case (op_class)
          CLS_RTYPE, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
            gp_out = rb_sel; Yin = 1'b1;
          end
          CLS_MULDIV: begin
            gp_out = ra_sel; Yin = 1'b1;
          end
          default: Yin = 1'b0;
        endcase
      end
      ST_T4: begin
        Zin = 1'b1;
        case (op_class)
          CLS_RTYPE:  begin gp_out = rc_sel; alu_op = opcode;  end
          CLS_IMM:    begin Cout = 1'b1;     alu_op = opcode;  end
          CLS_MULDIV: begin gp_out = rb_sel; alu_op = opcode;  end
          default:    begin Cout = 1'b1;     alu_op = ALU_ADD; end
        endcase
      end
      ST_T5: begin
        Zlowout = 1'b1;
        case (op_class)
          CLS_LD, CLS_ST: MARin = 1'b1;
          CLS_MULDIV:     LOin  = 1'b1;
          default:        gp_in = ra_sel;
        endcase
      end
      ST_T6: begin
        case (op_class)
          CLS_LD:     begin Read = 1'b1;     MDRin = 1'b1; end
          CLS_ST:     begin gp_out = ra_sel; MDRin = 1'b1; end
          CLS_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1;  end
          default:    MDRin = 1'b0;
        endcase
      end
      ST_T7: begin
        case (op_class)
          CLS_LD:  begin MDRout = 1'b1; gp_in = ra_sel; end
          CLS_ST:  Write = 1'b1;
          default: Write = 1'b0;
        endcase
      end
      default: running = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench: each instruction is expanded into its expected
// per-step strobe list from the opcode rules, then replayed against the DUT.
module tb_control_sequencer;

  logic        clock, clear, mem_ready, stop;
  logic [31:0] ir;
  logic [15:0] gp_out, gp_in;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout;
  logic        HIin, LOin, Zin, PCin, MDRin, MARin, IRin, Yin, IncPC, Read, Write;
  logic [4:0]  alu_op;
  logic        running, illegal;
  logic [3:0]  step;

  typedef struct packed {
    logic [15:0] gpo, gpi;
    logic hio, loo, zho, zlo, pco, mdro, co;
    logic hii, loi, zi, pci, mdri, mari, iri, yi, inc, rd, wr;
    logic [4:0] alu;
    logic run;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic w;
  } phase_t;

  ctl_t   obs;
  phase_t q[$];
  int     n_vec = 0;
  int     n_err = 0;
  logic   exp_ill = 1'b0;

  assign obs = {gp_out, gp_in, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout,
                HIin, LOin, Zin, PCin, MDRin, MARin, IRin, Yin, IncPC, Read, Write,
                alu_op, running};

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .gp_out(gp_out), .gp_in(gp_in), .HIout(HIout), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
    .Cout(Cout), .HIin(HIin), .LOin(LOin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .MARin(MARin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .alu_op(alu_op), .running(running),
    .illegal(illegal), .step(step)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  function automatic ctl_t blank();
    ctl_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  // Expand one instruction into its expected step list; w marks a memory wait step.
  task automatic build(input logic [31:0] w, output bit ends_halt, output bit traps);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit undef;
    ctl_t c;
    op = w[31:27]; ra = w[26:23]; rb = w[22:19]; rc = w[18:15];
    undef = (op >= 5'd16) && (op != 5'd26) && (op != 5'd27);
    ends_halt = 1'b0;
    traps = 1'b0;
    q.delete();
    c = blank(); c.pco = 1; c.mari = 1; c.inc = 1; c.zi = 1; q.push_back({c, 1'b0});
    c = blank(); c.zlo = 1; c.pci = 1; c.rd = 1; c.mdri = 1; q.push_back({c, 1'b1});
    c = blank(); c.mdro = 1; c.iri = 1;                      q.push_back({c, 1'b0});
    if (op <= 5'd13) begin
      c = blank(); c.gpo = oh(rb); c.yi = 1; q.push_back({c, 1'b0});
      c = blank(); c.zi = 1;
      if (op >= 5'd3 && op <= 5'd10) begin c.gpo = oh(rc); c.alu = op; end
      else begin c.co = 1; c.alu = (op >= 5'd11) ? op : 5'd3; end
      q.push_back({c, 1'b0});
      c = blank(); c.zlo = 1;
      if (op == 5'd0 || op == 5'd2) c.mari = 1; else c.gpi = oh(ra);
      q.push_back({c, 1'b0});
      if (op == 5'd0) begin
        c = blank(); c.rd = 1; c.mdri = 1;       q.push_back({c, 1'b1});
        c = blank(); c.mdro = 1; c.gpi = oh(ra); q.push_back({c, 1'b0});
      end
      if (op == 5'd2) begin
        c = blank(); c.gpo = oh(ra); c.mdri = 1; q.push_back({c, 1'b0});
        c = blank(); c.wr = 1;                   q.push_back({c, 1'b1});
      end
    end else if (op == 5'd14 || op == 5'd15) begin
      c = blank(); c.gpo = oh(ra); c.yi = 1;             q.push_back({c, 1'b0});
      c = blank(); c.gpo = oh(rb); c.alu = op; c.zi = 1; q.push_back({c, 1'b0});
      c = blank(); c.zlo = 1; c.loi = 1;                 q.push_back({c, 1'b0});
      c = blank(); c.zho = 1; c.hii = 1;                 q.push_back({c, 1'b0});
    end else begin
      c = blank(); q.push_back({c, 1'b0});
      ends_halt = (op == 5'd27);
`ifdef ILLEGAL_TRAP_EN
      if (undef) begin ends_halt = 1'b1; traps = 1'b1; end
`endif
    end
  endtask

  // res: 0 = back to fetch, 1 = halted, 2 = aborted by clear
  task automatic run_instr(input logic [31:0] w, input int stop_ph, input int force_w,
                           input int abort_at, output int res);
    bit h, tr, seen;
    int cyc, waits;
    phase_t p;
    build(w, h, tr);
    seen = 0; cyc = 0; res = 0;
    for (int i = 0; i < q.size(); i++) begin
      p = q[i];
      waits = 0;
      forever begin
        @(negedge clock);
        if (i == 0 && waits == 0) ir = w;
        if (cyc == abort_at) begin
          clear = 1'b0;
          #1;
          check_eq("abort_outputs", 64'(obs), 64'(0));
          exp_ill = 1'b0;
          res = 2;
          return;
        end
        check_eq($sformatf("op%0d_step%0d", w[31:27], i), 64'(obs), 64'(p.c));
        check_eq("bus_single", 64'(($countones(gp_out) +
                 $countones({HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout})) <= 1),
                 64'(1));
        check_eq("illegal_running", 64'(illegal), 64'(exp_ill));
        stop = (i == stop_ph && waits == 0);
        seen = seen | stop;
        if (p.w) begin
          if (i > 2 && force_w > 0) mem_ready = (waits >= force_w);
          else mem_ready = (waits >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        cyc++;
        if (p.w && !mem_ready) waits++;
        else break;
      end
    end
    if (h || seen) res = 1;
    if (tr) exp_ill = 1'b1;
  endtask

  task automatic halt_check();
    repeat (4) begin
      @(negedge clock);
      check_eq("halt_outputs", 64'(obs), 64'(0));
      check_eq("halt_illegal", 64'(illegal), 64'(exp_ill));
      stop = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic restart();
    clear = 1'b0;
    exp_ill = 1'b0;
    stop = 1'b0;
    #1;
    check_eq("reset_outputs", 64'(obs), 64'(0));
    @(negedge clock);
    check_eq("reset_hold", 64'(obs), 64'(0));
    check_eq("reset_illegal", 64'(illegal), 64'(0));
    clear = 1'b1;
    #1;
    check_eq("idle_outputs", 64'(obs), 64'(0));
  endtask

  task automatic exec(input logic [31:0] w, input int stop_ph, input int force_w,
                      input int abort_at);
    int res;
    run_instr(w, stop_ph, force_w, abort_at, res);
    if (res == 1) begin
      halt_check();
      restart();
    end else if (res == 2) begin
      @(negedge clock);
      check_eq("abort_no_strobes", 64'(obs), 64'(0));
      restart();
    end
  endtask

  initial begin
    int r, op, sp;
    clock = 1'b0; clear = 1'b0; ir = '0; mem_ready = 1'b0; stop = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check_eq("reset_outputs", 64'(obs), 64'(0));
      check_eq("reset_illegal", 64'(illegal), 64'(0));
    end
    mem_ready = 1'b1;
    clear = 1'b1;
    #1;
    check_eq("idle_outputs", 64'(obs), 64'(0));

    exec(mk(5'd3, 4'd3, 4'd1, 19'h10000), -1, 0, -1);         // add R3,R1,R2
    exec(mk(5'd0, 4'd1, 4'd2, 19'h00045), -1, 3, -1);         // ld R1,0x45(R2)
    exec(mk(5'd14, 4'd4, 4'd5, 19'h0), -1, 0, -1);            // mul R4,R5
    exec(mk(5'd2, 4'd6, 4'd7, 19'h00012), -1, 2, -1);         // st
    exec(mk(5'd1, 4'd8, 4'd0, 19'h7FFFF), -1, 0, -1);         // ldi
    exec(mk(5'd12, 4'd9, 4'd10, 19'h00003), -1, 0, -1);       // andi
    exec(mk(5'd26, 4'd0, 4'd0, 19'h0), -1, 0, -1);            // nop
    exec(mk(5'd31, 4'd2, 4'd3, 19'h0), -1, 0, -1);            // undefined opcode
    exec(mk(5'd4, 4'd1, 4'd2, 19'h18000), 4, 0, -1);          // sub, stop in T4
    exec(mk(5'd0, 4'd1, 4'd2, 19'h00045), -1, 3, 8);          // clear mid-wait
    exec(mk(5'd15, 4'd11, 4'd12, 19'h0), -1, 0, -1);          // div
    exec(mk(5'd27, 4'd0, 4'd0, 19'h0), 3, 0, -1);             // halt with stop

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r <= 15)      op = r;
      else if (r == 16) op = 26;
      else if (r == 17) op = 27;
      else if (r == 18) begin
        op = $urandom_range(16, 29);
        if (op >= 26) op = op + 2;
      end else op = $urandom_range(0, 15);
      sp = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
      exec({5'(op), 27'($urandom)}, sp, 0,
           ($urandom_range(0, 24) == 0) ? $urandom_range(0, 8) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
